conv_stream_kxk: RTL

CONV_STREAM_KXK -- requirements
Module: conv_stream_kxk

---
 rtl/conv_pkg.sv | 34 +++
 rtl/conv_stream_kxk_if.sv | 28 ++
 rtl/conv_line_buffer.sv | 26 ++
 rtl/conv_stream_kxk.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared helpers for the KxK streaming convolution: width math, result count and FSM encoding.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  // Ceiling log2, bounded loop so it stays a legal constant function.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned acc_bw(input int unsigned i_bw, input int unsigned w_bw,
                                         input int unsigned k);
    return i_bw + w_bw + clog2(k * k);
  endfunction

  function automatic int unsigned results_per_frame(input int unsigned i_size,
                                                    input int unsigned k,
                                                    input int unsigned stride);
    int unsigned n;
    n = (i_size - k) / stride + 1;
    return n * n;
  endfunction

endpackage

// File: rtl/conv_stream_kxk_if.sv
// Pixel stream in / convolution results out for conv_stream_kxk.
interface conv_stream_kxk_if #(
  parameter int unsigned I_BW = 8,
  parameter int unsigned O_BW = 16,
  parameter int unsigned CO   = 4
);
  import conv_pkg::*;

  localparam int unsigned CH_BW = clog2(CO) + 1;

  logic                    i_valid;
  logic signed [I_BW-1:0]  i_fmap;
  logic signed [O_BW-1:0]  o_conv_result;
  logic                    o_conv_valid;
  logic [CH_BW-1:0]        o_ch_idx;
  logic                    o_frame_end;
  logic                    o_all_end;

  modport master (
    output i_valid, i_fmap,
    input  o_conv_result, o_conv_valid, o_ch_idx, o_frame_end, o_all_end
  );

  modport slave (
    input  i_valid, i_fmap,
    output o_conv_result, o_conv_valid, o_ch_idx, o_frame_end, o_all_end
  );
endinterface

// File: rtl/conv_line_buffer.sv
// One image row of delay: q_o is the sample pushed DEPTH enables ago.
module conv_line_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (en_i) begin
      mem_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_stream_kxk.sv
// Streaming KxK convolution over CO sequential frames, 2-cycle product/sum pipeline.
// Define CONV_STREAM_RELU_EN to clamp negative saturated results to zero.
module conv_stream_kxk
  import conv_pkg::*;
#(
  parameter int unsigned I_BW   = 8,
  parameter int unsigned W_BW   = 8,
  parameter int unsigned O_BW   = 16,
  parameter int unsigned I_SIZE = 28,
  parameter int unsigned K_SIZE = 5,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned CO     = 4
) (
  input  logic                              clk,
  input  logic                              global_rst_n,
  input  logic                              rst,
  input  logic [CO*K_SIZE*K_SIZE*W_BW-1:0]  i_weight,
  conv_stream_kxk_if.slave                  s
);

  localparam int unsigned NTAP   = K_SIZE * K_SIZE;
  localparam int unsigned P_BW   = I_BW + W_BW;
  localparam int unsigned ACC_BW = acc_bw(I_BW, W_BW, K_SIZE);
  localparam int unsigned SAT_BW = (ACC_BW > O_BW) ? ACC_BW : O_BW;
  localparam int unsigned CH_BW  = clog2(CO) + 1;
  localparam int unsigned POS_BW = clog2(I_SIZE);
  localparam int unsigned LAST   = I_SIZE - 1;
  localparam logic signed [O_BW-1:0] O_MAX = {1'b0, {(O_BW-1){1'b1}}};
  localparam logic signed [O_BW-1:0] O_MIN = {1'b1, {(O_BW-1){1'b0}}};

  conv_state_e         state_q, state_d;
  logic [POS_BW-1:0]   r_q, r_d, c_q, c_d;
  logic [CH_BW-1:0]    ch_q, ch_d;
  logic                flush_q, flush_d;
  logic                frame_end_q, frame_end_d;
  logic                all_end_q, all_end_d;
  logic                accept_c, qual_c;

  // Frame sequencing; a synchronous clear overrides everything.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    ch_d        = ch_q;
    flush_d     = flush_q;
    frame_end_d = 1'b0;
    all_end_d   = all_end_q;
    accept_c    = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (s.i_valid) begin
          accept_c = 1'b1;
          state_d  = ST_RUN;
          if (c_q == POS_BW'(LAST)) begin
            c_d = '0;
            if (r_q == POS_BW'(LAST)) begin
              r_d     = '0;
              state_d = ST_FLUSH;
              flush_d = 1'b0;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) begin
          frame_end_d = 1'b1;
          ch_d        = ch_q + 1'b1;
          if (32'(ch_q) + 32'd1 < CO) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DONE;
            all_end_d = 1'b1;
          end
        end
      end
      ST_DONE: all_end_d = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      state_d     = ST_IDLE;
      r_d         = '0;
      c_d         = '0;
      ch_d        = '0;
      flush_d     = 1'b0;
      frame_end_d = 1'b0;
      all_end_d   = 1'b0;
      accept_c    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q     <= ST_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      ch_q        <= '0;
      flush_q     <= 1'b0;
      frame_end_q <= 1'b0;
      all_end_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      ch_q        <= ch_d;
      flush_q     <= flush_d;
      frame_end_q <= frame_end_d;
      all_end_q   <= all_end_d;
    end
  end

  // Window ending at (r,c) qualifies once fully inside the frame and on the stride grid.
  always_comb begin
    qual_c = 1'b0;
    if (32'(r_q) >= K_SIZE - 1 && 32'(c_q) >= K_SIZE - 1)
      qual_c = ((32'(r_q) - (K_SIZE - 1)) % STRIDE == 0) &&
               ((32'(c_q) - (K_SIZE - 1)) % STRIDE == 0);
  end

  // chain[0] is the incoming pixel, chain[g+1] the same column g+1 rows earlier.
  logic [I_BW-1:0] chain [K_SIZE];
  assign chain[0] = s.i_fmap;

  for (genvar g = 0; g < K_SIZE - 1; g++) begin : g_lb
    conv_line_buffer #(.WIDTH(I_BW), .DEPTH(I_SIZE)) u_lb (
      .clk   (clk),
      .rst_n (global_rst_n),
      .en_i  (accept_c),
      .d_i   (chain[g]),
      .q_o   (chain[g+1])
    );
  end

  logic signed [I_BW-1:0] win_q [K_SIZE][K_SIZE];
  logic signed [I_BW-1:0] win_d [K_SIZE][K_SIZE];
  logic signed [P_BW-1:0] prod_q [NTAP];
  logic signed [P_BW-1:0] prod_d [NTAP];
  logic [CH_BW-1:0]       ch_sel_c;

  assign ch_sel_c = (32'(ch_q) < CO) ? ch_q : '0;

  // Products are taken from the window as it will look after this pixel lands.
  always_comb begin
    for (int unsigned kr = 0; kr < K_SIZE; kr++) begin
      for (int unsigned kc = 0; kc + 1 < K_SIZE; kc++) win_d[kr][kc] = win_q[kr][kc+1];
      win_d[kr][K_SIZE-1] = $signed(chain[K_SIZE-1-kr]);
    end
    for (int unsigned kr = 0; kr < K_SIZE; kr++) begin
      for (int unsigned kc = 0; kc < K_SIZE; kc++) begin
        prod_d[kr*K_SIZE+kc] = P_BW'(win_d[kr][kc]) *
          P_BW'($signed(i_weight[(32'(ch_sel_c)*NTAP + kr*K_SIZE + kc)*W_BW +: W_BW]));
      end
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      for (int unsigned kr = 0; kr < K_SIZE; kr++)
        for (int unsigned kc = 0; kc < K_SIZE; kc++) win_q[kr][kc] <= '0;
      for (int unsigned i = 0; i < NTAP; i++) prod_q[i] <= '0;
    end else if (accept_c) begin
      win_q  <= win_d;
      prod_q <= prod_d;
    end
  end

  logic signed [ACC_BW-1:0] acc_c;
  logic signed [SAT_BW-1:0] acc_ext_c;
  logic signed [O_BW-1:0]   res_d;

  always_comb begin
    acc_c = '0;
    for (int unsigned i = 0; i < NTAP; i++) acc_c = acc_c + ACC_BW'(prod_q[i]);
    acc_ext_c = SAT_BW'(acc_c);
    if (acc_ext_c > SAT_BW'(O_MAX))      res_d = O_MAX;
    else if (acc_ext_c < SAT_BW'(O_MIN)) res_d = O_MIN;
    else                                 res_d = O_BW'(acc_ext_c);
`ifdef CONV_STREAM_RELU_EN
    if (res_d[O_BW-1]) res_d = '0;
`else
    res_d = res_d;
`endif
  end

  logic                   v1_q, res_vld_q;
  logic signed [O_BW-1:0] res_q;

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      v1_q      <= 1'b0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      v1_q      <= accept_c & qual_c;
      res_vld_q <= v1_q & ~rst;
      if (rst)       res_q <= '0;
      else if (v1_q) res_q <= res_d;
    end
  end

  assign s.o_conv_result = res_q;
  assign s.o_conv_valid  = res_vld_q;
  assign s.o_ch_idx      = ch_q;
  assign s.o_frame_end   = frame_end_q;
  assign s.o_all_end     = all_end_q;

endmodule
